// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings and defaults for the MIPS memory arbiter
package mips_pkg;
   localparam int DEF_AW = 10;
   localparam int DEF_DW = 32;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_DM   = 2'd2,
      OWN_LD   = 2'd3
   } owner_t;

   typedef enum logic {
      ST_NORMAL = 1'b0,
      ST_BOOST  = 1'b1
   } arb_state_t;
endpackage

// File: rtl/mips_prio_sel.sv
// rtl/mips_prio_sel.sv - 3-request fixed-priority picker; boost promotes fetch to the top
module mips_prio_sel (
   input  logic req_ld,
   input  logic req_dm,
   input  logic req_if,
   input  logic boost,
   output logic gnt_ld,
   output logic gnt_dm,
   output logic gnt_if
);
   always_comb begin
      gnt_ld = 1'b0;
      gnt_dm = 1'b0;
      gnt_if = 1'b0;
      if (boost && req_if) begin
         gnt_if = 1'b1;
      end else if (req_ld) begin
         gnt_ld = 1'b1;
      end else if (req_dm) begin
         gnt_dm = 1'b1;
      end else if (req_if) begin
         gnt_if = 1'b1;
      end
   end
endmodule

// File: rtl/mips_mem_arbiter.sv
// rtl/mips_mem_arbiter.sv - single-port memory arbiter for loader, data stage and fetch
module mips_mem_arbiter
   import mips_pkg::*;
#(
   parameter int AW           = DEF_AW,
   parameter int DW           = DEF_DW,
   parameter int STARVE_LIMIT = 4
) (
   input  logic          clk1,
   input  logic          rst,
   input  logic          halted,
   input  logic          ld_req,
   input  logic          ld_we,
   input  logic [AW-1:0] ld_addr,
   input  logic [DW-1:0] ld_wdata,
   output logic          ld_gnt,
   input  logic          dm_req,
   input  logic          dm_we,
   input  logic [AW-1:0] dm_addr,
   input  logic [DW-1:0] dm_wdata,
   output logic          dm_gnt,
   output logic          dm_rvalid,
   output logic [DW-1:0] dm_rdata,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_gnt,
   output logic          if_rvalid,
   output logic [DW-1:0] if_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);
   localparam int SW = $clog2(STARVE_LIMIT) + 1;
   localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

   arb_state_t    state, state_next;
   owner_t        rd_owner, rd_owner_next;
   logic [SW-1:0] starve_cnt, starve_next;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q, if_rdata_q, dm_rdata_q;
   logic          if_eff, sel_ld, sel_dm, sel_if;

   assign if_eff = if_req & ~halted;

   mips_prio_sel u_prio_sel (
      .req_ld (ld_req),
      .req_dm (dm_req),
      .req_if (if_eff),
      .boost  (state == ST_BOOST),
      .gnt_ld (sel_ld),
      .gnt_dm (sel_dm),
      .gnt_if (sel_if)
   );

   assign ld_gnt = sel_ld & ~rst;
   assign dm_gnt = sel_dm & ~rst;
   assign if_gnt = sel_if & ~rst;

   // Address and write data hold their last driven value when idle
   always_comb begin
      mem_en    = ld_gnt | dm_gnt | if_gnt;
      mem_we    = 1'b0;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      if (ld_gnt) begin
         mem_we    = ld_we;
         mem_addr  = ld_addr;
         mem_wdata = ld_wdata;
      end else if (dm_gnt) begin
         mem_we    = dm_we;
         mem_addr  = dm_addr;
         mem_wdata = dm_wdata;
      end else if (if_gnt) begin
         mem_addr  = if_addr;
      end
   end

   always_comb begin
      starve_next = '0;
      if (if_eff && !if_gnt) begin
         starve_next = (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 1'b1;
      end
      // Boost lasts one cycle; fetch is then either served or no longer requesting
      state_next = ST_NORMAL;
      if (state == ST_NORMAL && starve_next == LIMIT) begin
         state_next = ST_BOOST;
      end
      rd_owner_next = OWN_NONE;
      if (ld_gnt && !ld_we) begin
         rd_owner_next = OWN_LD;
      end else if (dm_gnt && !dm_we) begin
         rd_owner_next = OWN_DM;
      end else if (if_gnt) begin
         rd_owner_next = OWN_IF;
      end
   end

   assign if_rvalid = (rd_owner == OWN_IF) & ~rst;
   assign dm_rvalid = (rd_owner == OWN_DM) & ~rst;
   assign if_rdata  = if_rvalid ? mem_rdata : if_rdata_q;
   assign dm_rdata  = dm_rvalid ? mem_rdata : dm_rdata_q;

   always_ff @(posedge clk1) begin
      if (rst) begin
         state      <= ST_NORMAL;
         starve_cnt <= '0;
         rd_owner   <= OWN_NONE;
         addr_q     <= '0;
         wdata_q    <= '0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else begin
         state      <= state_next;
         starve_cnt <= starve_next;
         rd_owner   <= rd_owner_next;
         addr_q     <= mem_addr;
         wdata_q    <= mem_wdata;
         if_rdata_q <= if_rdata;
         dm_rdata_q <= dm_rdata;
      end
   end
endmodule

// File: doc/mips_mem_arbiter.md
MIPS_MEM_ARBITER -- requirements
Module: mips_mem_arbiter

Interface
REQ-001 Parameters SHALL be:
- AW, default 10, word-address width.
- DW, default 32, data width.
- STARVE_LIMIT, default 4, consecutive fetch denials before fetch is boosted.

REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk1  in  1  sole clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- halted  in  1  pipeline halted; while high, fetch requests are ignored.
- ld_req  in  1  loader (preload/debug) request.
- ld_we  in  1  loader write enable.
- ld_addr  in  AW  loader address.
- ld_wdata  in  DW  loader write data.
- ld_gnt  out  1  loader granted this cycle.
- dm_req  in  1  data-stage load/store request.
- dm_we  in  1  data-stage write enable.
- dm_addr  in  AW  data-stage address.
- dm_wdata  in  DW  data-stage write data.
- dm_gnt  out  1  data-stage granted this cycle.
- dm_rvalid  out  1  data-stage read data valid.
- dm_rdata  out  DW  data-stage read data.
- if_req  in  1  instruction fetch request (read only).
- if_addr  in  AW  fetch address.
- if_gnt  out  1  fetch granted this cycle.
- if_rvalid  out  1  fetch read data valid.
- if_rdata  out  DW  fetch read data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid the cycle after mem_en with mem_we=0.

Function
REQ-003 Grants and the mem_* outputs SHALL be combinational from the current requests and registered state; at most one of ld_gnt, dm_gnt, if_gnt SHALL be high in any cycle.
REQ-004 Effective fetch request SHALL be if_req AND NOT halted.
REQ-005 The FSM SHALL have states NORMAL and BOOST.
- NORMAL priority: loader > data > fetch.
- BOOST priority: fetch > loader > data.
REQ-006 The granted requester's we/addr/wdata SHALL drive mem_*, with mem_en=1; mem_we SHALL be 0 for fetch; with no grant, mem_en=mem_we=0 and mem_addr/mem_wdata SHALL hold their previous values.
REQ-007 A 2-bit registered rd_owner (NONE/IF/DM/LD) SHALL record the owner of each granted read; next cycle, mem_rdata SHALL be routed to if_rdata/dm_rdata with a one-cycle if_rvalid/dm_rvalid pulse; loader reads SHALL complete silently (no rvalid output).
REQ-008 Read latency SHALL be exactly 1 cycle grant-to-rvalid; back-to-back grants SHALL be allowed every cycle (full throughput).
REQ-009 starve_cnt (width clog2(STARVE_LIMIT)+1) SHALL:
- increment each cycle the effective fetch request is high and if_gnt is low;
- clear on if_gnt or when the effective fetch request is low;
- saturate at STARVE_LIMIT.
REQ-010 NORMAL -> BOOST SHALL occur when starve_cnt reaches STARVE_LIMIT; BOOST -> NORMAL SHALL occur after exactly one BOOST cycle, or immediately if fetch is no longer requesting.
REQ-011 Rising halted during BOOST SHALL force NORMAL next cycle; an in-flight read SHALL still deliver its rvalid.
REQ-012 Writes SHALL produce no rvalid; a read and a write to the same address in consecutive cycles SHALL be ordered by grant order.
REQ-013 Simultaneous requests from all three in NORMAL with starve_cnt<STARVE_LIMIT SHALL grant the loader only; ungranted requesters SHALL hold their request (arbiter holds no pending queue).

Reset
REQ-014 While rst is high at a clk1 edge, the block SHALL enter NORMAL and set starve_cnt=0, rd_owner=NONE, if_rvalid=dm_rvalid=0, if_rdata=dm_rdata=0, mem_addr=0, mem_wdata=0.
REQ-015 Grant outputs and mem_en SHALL be 0 during any cycle where rst is high.
REQ-016 A read granted in the cycle rst asserts SHALL NOT produce rvalid.

Structure
REQ-017 Owner encodings (NONE/IF/DM/LD), FSM state encodings and default AW/DW SHALL live in the shared package mips_pkg.
REQ-018 Priority selection SHALL be one sub-module, mips_prio_sel (3-request fixed-priority picker with a boost input); everything else stays in mips_mem_arbiter.

Verification
REQ-019 Reset: rst high 2 cycles with all requests high -> all gnt=0, mem_en=0, rvalid=0; first cycle after release ld_gnt=1.
REQ-020 Fetch only: if_req=1, if_addr=4, memory[4]=32'h00222000 -> if_gnt same cycle, if_rvalid=1 and if_rdata=32'h00222000 next cycle.
REQ-021 Starvation: dm_req and if_req held high 10 cycles, STARVE_LIMIT=4 -> grant pattern dm,dm,dm,dm,if,dm,dm,dm,dm,if.
REQ-022 Halt: halted=1, if_req=1, dm_req=0 for 6 cycles -> if_gnt=0, mem_en=0, starve_cnt stays 0, FSM stays NORMAL.
REQ-023 Loader preload: ld writes 32'h2801000a to address 0, then dm reads address 0 -> dm_rvalid with 32'h2801000a exactly 1 cycle after dm_gnt.
REQ-024 Reset mid-read: dm read granted, rst asserted the same cycle -> no dm_rvalid in the following cycle.
